// File: rtl/sa_deserializer.sv
// sa_deserializer: collects the serial adder's MSB-first result into
// WIDTH-bit words, queues them in a DEPTH-entry FIFO and presents them on a
// valid/ready interface. Flags truncated frames and FIFO overflow.
// Optional build macro SA_DESER_PARITY_EN: each frame carries one trailing
// even-parity bit, checked on completion.
//
// state  | meaning
// IDLE   | no frame in progress, waiting for en_i
// SHIFT  | collecting data bits of a frame
// PARITY | (SA_DESER_PARITY_EN only) waiting for the trailing parity bit
module sa_deserializer #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic                     ser_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     abort_o,
    output logic                     ovf_o,
    output logic                     parity_err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef SA_DESER_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             push;
    logic [WIDTH-1:0] push_word;
    logic             abort_q, abort_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    count_q, count_d, old_left;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q;
    logic             pop, full, do_push;

`ifdef SA_DESER_PARITY_EN
    logic             perr_q, perr_d;
`endif

    // Frame assembly FSM: next state, shift register, bit counter, completion.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        push_word = shift_q;
        abort_d   = 1'b0;
`ifdef SA_DESER_PARITY_EN
        perr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    shift_d = {{(WIDTH-1){1'b0}}, ser_i};
                    cnt_d   = BW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (en_i) begin
                    shift_d = {shift_q[WIDTH-2:0], ser_i};
                    if (cnt_q == LAST_BIT - BW'(1)) begin
`ifdef SA_DESER_PARITY_EN
                        cnt_d   = LAST_BIT;
                        state_d = PARITY;
`else
                        push      = 1'b1;
                        push_word = shift_d;
                        cnt_d     = '0;
                        state_d   = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + BW'(1);
                    end
                end else begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = IDLE;
                end
            end
`ifdef SA_DESER_PARITY_EN
            PARITY: begin
                cnt_d   = '0;
                state_d = IDLE;
                if (en_i) begin
                    push      = 1'b1;
                    push_word = shift_q;
                    perr_d    = ^{shift_q, ser_i};
                end else begin
                    abort_d = 1'b1;
                    shift_d = '0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FIFO bookkeeping: pointers, occupancy and the next registered head word.
    always_comb begin
        pop      = valid_q && ready_i;
        full     = (count_q == FULL);
        do_push  = push && (!full || pop);
        ovf_d    = push && full && !pop;
        rd_d     = rd_q + PW'(pop);
        wr_d     = wr_q + PW'(do_push);
        old_left = count_q - CW'(pop);
        count_d  = old_left + CW'(do_push);
        if (count_d == '0) begin
            data_d = '0;
        end else if (old_left == '0) begin
            data_d = push_word;
        end else begin
            data_d = mem_q[rd_d];
        end
    end

    // FSM, FIFO control and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            abort_q <= 1'b0;
            ovf_q   <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            abort_q <= abort_d;
            ovf_q   <= ovf_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= (count_d != '0);
        end
    end

    // FIFO storage; stale entries are harmless since pointers reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_word;
        end
    end

`ifdef SA_DESER_PARITY_EN
    // Parity error pulse, aligned with the push of the offending word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign count_o = count_q;
    assign abort_o = abort_q;
    assign ovf_o   = ovf_q;

endmodule
